pic_service_sequencer: RTL and testbench



---
 rtl/pic_service_sequencer_if.sv | 30 +++
 rtl/pic_service_sequencer.sv | 143 ++++++++++++++
 tb/tb_pic_service_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_service_sequencer_if.sv
// Signal bundle between the IRR stage / CPU side and the PIC service sequencer.
// The sequencer takes the slave view; the driving side takes the master view.
interface pic_service_sequencer_if;
    logic [7:0] interrupt_req_reg;
    logic [7:0] interrupt_mask;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       auto_eoi;
    logic       eoi_valid;
    logic       eoi_specific;
    logic       eoi_rotate;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] clear_ir_line;
    logic [7:0] in_service_reg;
    logic [7:0] data_out;
    logic       data_out_en;

    modport master (
        output interrupt_req_reg, interrupt_mask, inta_n, vector_base, auto_eoi,
               eoi_valid, eoi_specific, eoi_rotate, eoi_level,
        input  int_out, clear_ir_line, in_service_reg, data_out, data_out_en
    );

    modport slave (
        input  interrupt_req_reg, interrupt_mask, inta_n, vector_base, auto_eoi,
               eoi_valid, eoi_specific, eoi_rotate, eoi_level,
        output int_out, clear_ir_line, in_service_reg, data_out, data_out_en
    );
endinterface

// File: rtl/pic_service_sequencer.sv
// Priority resolver, ISR/EOI handling and 8086 two-pulse INTA sequencer.
//   state | meaning
//   IDLE  | waiting for first INTA falling edge; int_out follows qualification
//   ACK1  | first INTA low; level latched, ISR set, clear pulse issued
//   GAP   | between the two INTA pulses
//   ACK2  | second INTA low; vector byte driven on data bus
module pic_service_sequencer #(
    parameter int NUM_IR = 8
) (
    input logic                    clk,
    input logic                    reset_n,
    pic_service_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;

    state_t     r_state;
    logic       r_inta_d;
    logic       r_int;
    logic       r_spurious;
    logic       r_dout_en;
    logic [7:0] r_clear;
    logic [7:0] r_isr;
    logic [7:0] r_dout;
    logic [2:0] r_lowest;
    logic [2:0] r_ack_level;

    // Returns {found, level} of the highest-priority set bit, scanning upward from low+1.
    function automatic logic [3:0] find_top(input logic [7:0] v, input logic [2:0] low);
        logic       found;
        logic [2:0] lvl;
        logic [2:0] idx;
        found = 1'b0;
        lvl   = 3'd0;
        for (int k = 1; k <= NUM_IR; k++) begin
            idx = low + k[2:0];
            if (!found && v[idx]) begin
                found = 1'b1;
                lvl   = idx;
            end
        end
        return {found, lvl};
    endfunction

    // Smaller rank means higher priority.
    function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] low);
        return lvl - low - 3'd1;
    endfunction

    logic [7:0] w_pending;
    logic [3:0] w_cand;
    logic [3:0] w_isr_top;
    logic       w_qual;
    logic       w_inta_fall;
    logic       w_ack_take;
    logic       w_aeoi_clr;
    logic       w_eoi_hit;
    logic [2:0] w_eoi_lvl;
    logic [7:0] w_isr_next;
    logic [2:0] w_lowest_next;

    assign w_pending   = bus.interrupt_req_reg & ~bus.interrupt_mask;
    assign w_cand      = find_top(w_pending, r_lowest);
    assign w_isr_top   = find_top(r_isr, r_lowest);
    assign w_qual      = w_cand[3] && (!w_isr_top[3] ||
                         (rank(w_cand[2:0], r_lowest) < rank(w_isr_top[2:0], r_lowest)));
    assign w_inta_fall = !bus.inta_n && r_inta_d;
    assign w_ack_take  = (r_state == IDLE) && w_inta_fall && w_qual;
    assign w_aeoi_clr  = (r_state == ACK2) && bus.inta_n && bus.auto_eoi && !r_spurious;
    assign w_eoi_lvl   = bus.eoi_specific ? bus.eoi_level : w_isr_top[2:0];
    assign w_eoi_hit   = bus.eoi_valid &&
                         (bus.eoi_specific ? r_isr[bus.eoi_level] : w_isr_top[3]);

    // Clears first, acknowledge set last so a same-bit collision leaves the bit set.
    always_comb begin
        w_isr_next    = r_isr;
        w_lowest_next = r_lowest;
        if (w_eoi_hit) begin
            w_isr_next[w_eoi_lvl] = 1'b0;
            if (bus.eoi_rotate) w_lowest_next = w_eoi_lvl;
        end
        if (w_aeoi_clr) begin
            w_isr_next[r_ack_level] = 1'b0;
            if (bus.eoi_rotate) w_lowest_next = r_ack_level;
        end
        if (w_ack_take) w_isr_next[w_cand[2:0]] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_inta_d    <= 1'b1;
            r_int       <= 1'b0;
            r_clear     <= '0;
            r_isr       <= '0;
            r_lowest    <= 3'd7;
            r_ack_level <= 3'd0;
            r_spurious  <= 1'b0;
            r_dout      <= '0;
            r_dout_en   <= 1'b0;
        end else begin
            r_inta_d <= bus.inta_n;
            r_isr    <= w_isr_next;
            r_lowest <= w_lowest_next;
            r_clear  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_inta_fall) begin
                        r_state     <= ACK1;
                        r_int       <= 1'b0;
                        r_ack_level <= w_qual ? w_cand[2:0] : 3'd7;
                        r_spurious  <= !w_qual;
                        if (w_qual) r_clear <= 8'(1) << w_cand[2:0];
                    end else begin
                        r_int <= w_qual;
                    end
                end
                ACK1: if (bus.inta_n) r_state <= GAP;
                GAP: begin
                    if (w_inta_fall) begin
                        r_state   <= ACK2;
                        r_dout    <= {bus.vector_base, r_ack_level};
                        r_dout_en <= 1'b1;
                    end
                end
                ACK2: begin
                    if (bus.inta_n) begin
                        r_state   <= IDLE;
                        r_dout_en <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.int_out        = r_int;
    assign bus.clear_ir_line  = r_clear;
    assign bus.in_service_reg = r_isr;
    assign bus.data_out       = r_dout;
    assign bus.data_out_en    = r_dout_en;

endmodule

// File: tb/tb_pic_service_sequencer.sv
// Self-checking bench for pic_service_sequencer: directed scenarios plus randomized
// acknowledge/EOI traffic compared against a priority-rank reference model.
module tb_pic_service_sequencer;

    logic clk;
    logic reset_n;
    pic_service_sequencer_if bus ();

    pic_service_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: ISR contents and the current lowest-priority level.
    bit [7:0] m_isr;
    int       m_low;

    function automatic int m_top(input bit [7:0] v);
        for (int r = 0; r < 8; r++) begin
            int l;
            l = (m_low + 1 + r) % 8;
            if (v[l]) return l;
        end
        return -1;
    endfunction

    function automatic int m_qual(input bit [7:0] req, input bit [7:0] mask);
        int c;
        int h;
        c = m_top(req & ~mask);
        if (c < 0) return -1;
        h = m_top(m_isr);
        if (h < 0) return c;
        if (((c - m_low + 7) % 8) < ((h - m_low + 7) % 8)) return c;
        return -1;
    endfunction

    function automatic void m_eoi(input bit spec, input bit rot, input int lvl);
        int t;
        t = spec ? lvl : m_top(m_isr);
        if (t >= 0 && m_isr[t]) begin
            m_isr[t] = 1'b0;
            if (rot) m_low = t;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_eoi(input bit spec, input bit rot, input bit [2:0] lvl);
        bus.eoi_valid    = 1'b1;
        bus.eoi_specific = spec;
        bus.eoi_rotate   = rot;
        bus.eoi_level    = lvl;
        step();
        bus.eoi_valid  = 1'b0;
        bus.eoi_rotate = 1'b0;
    endtask

    // Full two-pulse acknowledge; optional EOI strobe on the first falling edge.
    // Acknowledged lines are retired from the request vector as the IRR stage would.
    task automatic run_inta(input bit eoi_at_ack, input bit eoi_spec, input bit [2:0] eoi_lvl,
                            output logic [7:0] clr1, output logic [7:0] clr2,
                            output logic [7:0] isr1, output logic int1,
                            output logic [7:0] dout, output logic en,
                            output logic [7:0] isr_mid, output logic en_after,
                            output logic [7:0] isr_after);
        bus.inta_n       = 1'b0;
        bus.eoi_valid    = eoi_at_ack;
        bus.eoi_specific = eoi_spec;
        bus.eoi_level    = eoi_lvl;
        step();
        bus.eoi_valid = 1'b0;
        clr1 = bus.clear_ir_line;
        isr1 = bus.in_service_reg;
        int1 = bus.int_out;
        bus.interrupt_req_reg = bus.interrupt_req_reg & ~bus.clear_ir_line;
        step();
        clr2 = bus.clear_ir_line;
        bus.inta_n = 1'b1;
        step();
        step();
        bus.inta_n = 1'b0;
        step();
        dout    = bus.data_out;
        en      = bus.data_out_en;
        isr_mid = bus.in_service_reg;
        step();
        bus.inta_n = 1'b1;
        step();
        en_after  = bus.data_out_en;
        isr_after = bus.in_service_reg;
        step();
    endtask

    logic [7:0] c1, c2, i1, dv, im, ia;
    logic       t1, ev, ea;

    task automatic test_reset();
        reset_n = 1'b0;
        bus.interrupt_req_reg = 8'hFF;
        step();
        step();
        n_checks++; if (bus.int_out !== 1'b0) $display("FAIL reset_int got=%b exp=0", bus.int_out); else n_pass++;
        n_checks++; if (bus.clear_ir_line !== 8'h00) $display("FAIL reset_clr got=%h exp=00", bus.clear_ir_line); else n_pass++;
        n_checks++; if (bus.in_service_reg !== 8'h00) $display("FAIL reset_isr got=%h exp=00", bus.in_service_reg); else n_pass++;
        n_checks++; if (bus.data_out !== 8'h00) $display("FAIL reset_dout got=%h exp=00", bus.data_out); else n_pass++;
        n_checks++; if (bus.data_out_en !== 1'b0) $display("FAIL reset_en got=%b exp=0", bus.data_out_en); else n_pass++;
        bus.interrupt_req_reg = 8'h00;
        reset_n = 1'b1;
        m_isr = '0;
        m_low = 7;
        step();
    endtask

    task automatic test_single();
        bus.vector_base = 5'h11;
        bus.interrupt_mask = 8'h00;
        bus.interrupt_req_reg = 8'h08;
        n_checks++; if (bus.int_out !== 1'b0) $display("FAIL single_int_pre got=%b exp=0", bus.int_out); else n_pass++;
        step();
        n_checks++; if (bus.int_out !== 1'b1) $display("FAIL single_int got=%b exp=1", bus.int_out); else n_pass++;
        run_inta(0, 0, 0, c1, c2, i1, t1, dv, ev, im, ea, ia);
        m_isr[3] = 1'b1;
        n_checks++; if (c1 !== 8'h08) $display("FAIL single_clr got=%h exp=08", c1); else n_pass++;
        n_checks++; if (c2 !== 8'h00) $display("FAIL single_clr_width got=%h exp=00", c2); else n_pass++;
        n_checks++; if (i1 !== 8'h08) $display("FAIL single_isr got=%h exp=08", i1); else n_pass++;
        n_checks++; if (t1 !== 1'b0) $display("FAIL single_int_ack got=%b exp=0", t1); else n_pass++;
        n_checks++; if (dv !== 8'h8B) $display("FAIL single_dout got=%h exp=8b", dv); else n_pass++;
        n_checks++; if (ev !== 1'b1) $display("FAIL single_en got=%b exp=1", ev); else n_pass++;
        n_checks++; if (ea !== 1'b0) $display("FAIL single_en_drop got=%b exp=0", ea); else n_pass++;
    endtask

    task automatic test_nesting();
        bus.interrupt_req_reg = 8'h20;
        step();
        step();
        n_checks++; if (bus.int_out !== 1'b0) $display("FAIL nest_low_int got=%b exp=0", bus.int_out); else n_pass++;
        bus.interrupt_req_reg = 8'h02;
        step();
        n_checks++; if (bus.int_out !== 1'b1) $display("FAIL nest_high_int got=%b exp=1", bus.int_out); else n_pass++;
        run_inta(0, 0, 0, c1, c2, i1, t1, dv, ev, im, ea, ia);
        m_isr[1] = 1'b1;
        n_checks++; if (c1 !== 8'h02) $display("FAIL nest_clr got=%h exp=02", c1); else n_pass++;
        n_checks++; if (i1 !== 8'h0A) $display("FAIL nest_isr got=%h exp=0a", i1); else n_pass++;
        n_checks++; if (dv !== 8'h89) $display("FAIL nest_dout got=%h exp=89", dv); else n_pass++;
    endtask

    task automatic test_nonspecific_eoi();
        logic [7:0] exp_seq [3];
        exp_seq = '{8'h08, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) begin
            pulse_eoi(0, 0, 3'd0);
            m_eoi(0, 0, 0);
            n_checks++; if (bus.in_service_reg !== exp_seq[i]) $display("FAIL ns_eoi_%0d got=%h exp=%h", i, bus.in_service_reg, exp_seq[i]); else n_pass++;
        end
    endtask

    task automatic test_rotating();
        bus.interrupt_req_reg = 8'h04;
        step();
        run_inta(0, 0, 0, c1, c2, i1, t1, dv, ev, im, ea, ia);
        m_isr[2] = 1'b1;
        n_checks++; if (i1 !== 8'h04) $display("FAIL rot_setup_isr got=%h exp=04", i1); else n_pass++;
        pulse_eoi(1, 1, 3'd2);
        m_eoi(1, 1, 2);
        n_checks++; if (bus.in_service_reg !== 8'h00) $display("FAIL rot_eoi_isr got=%h exp=00", bus.in_service_reg); else n_pass++;
        bus.interrupt_req_reg = 8'h09;
        step();
        n_checks++; if (bus.int_out !== 1'b1) $display("FAIL rot_int got=%b exp=1", bus.int_out); else n_pass++;
        run_inta(0, 0, 0, c1, c2, i1, t1, dv, ev, im, ea, ia);
        m_isr[3] = 1'b1;
        n_checks++; if (c1 !== 8'h08) $display("FAIL rot_clr got=%h exp=08", c1); else n_pass++;
        n_checks++; if (dv !== 8'h8B) $display("FAIL rot_dout got=%h exp=8b", dv); else n_pass++;
        pulse_eoi(0, 0, 3'd0);
        m_eoi(0, 0, 0);
    endtask

    task automatic test_spurious();
        step();
        n_checks++; if (bus.int_out !== 1'b1) $display("FAIL spur_int got=%b exp=1", bus.int_out); else n_pass++;
        bus.interrupt_req_reg = 8'h00;
        step();
        step();
        run_inta(0, 0, 0, c1, c2, i1, t1, dv, ev, im, ea, ia);
        n_checks++; if (c1 !== 8'h00) $display("FAIL spur_clr got=%h exp=00", c1); else n_pass++;
        n_checks++; if (i1 !== m_isr) $display("FAIL spur_isr got=%h exp=%h", i1, m_isr); else n_pass++;
        n_checks++; if (dv !== 8'h8F) $display("FAIL spur_dout got=%h exp=8f", dv); else n_pass++;
        n_checks++; if (ev !== 1'b1) $display("FAIL spur_en got=%b exp=1", ev); else n_pass++;
    endtask

    task automatic test_aeoi();
        bus.auto_eoi = 1'b1;
        bus.interrupt_req_reg = 8'h10;
        step();
        run_inta(0, 0, 0, c1, c2, i1, t1, dv, ev, im, ea, ia);
        n_checks++; if (im !== 8'h10) $display("FAIL aeoi_isr_mid got=%h exp=10", im); else n_pass++;
        n_checks++; if (ia !== 8'h00) $display("FAIL aeoi_isr_after got=%h exp=00", ia); else n_pass++;
        bus.auto_eoi = 1'b0;
    endtask

    task automatic test_collision();
        bus.interrupt_req_reg = 8'h40;
        step();
        run_inta(1, 1, 3'd6, c1, c2, i1, t1, dv, ev, im, ea, ia);
        m_eoi(1, 0, 6);
        m_isr[6] = 1'b1;
        n_checks++; if (i1 !== 8'h40) $display("FAIL coll_same_isr got=%h exp=40", i1); else n_pass++;
        bus.interrupt_req_reg = 8'h10;
        step();
        run_inta(1, 0, 3'd0, c1, c2, i1, t1, dv, ev, im, ea, ia);
        m_eoi(0, 0, 0);
        m_isr[4] = 1'b1;
        n_checks++; if (i1 !== 8'h10) $display("FAIL coll_diff_isr got=%h exp=10", i1); else n_pass++;
        pulse_eoi(0, 0, 3'd0);
        m_eoi(0, 0, 0);
    endtask

    task automatic test_reset_mid();
        bus.interrupt_req_reg = 8'h08;
        step();
        bus.inta_n = 1'b0;
        step();
        step();
        bus.inta_n = 1'b1;
        step();
        reset_n = 1'b0;
        bus.interrupt_req_reg = 8'h00;
        #1;
        n_checks++; if (bus.in_service_reg !== 8'h00) $display("FAIL rmid_isr got=%h exp=00", bus.in_service_reg); else n_pass++;
        n_checks++; if (bus.int_out !== 1'b0) $display("FAIL rmid_int got=%b exp=0", bus.int_out); else n_pass++;
        n_checks++; if (bus.data_out_en !== 1'b0) $display("FAIL rmid_en got=%b exp=0", bus.data_out_en); else n_pass++;
        n_checks++; if (bus.data_out !== 8'h00) $display("FAIL rmid_dout got=%h exp=00", bus.data_out); else n_pass++;
        step();
        reset_n = 1'b1;
        m_isr = '0;
        m_low = 7;
        step();
        bus.interrupt_req_reg = 8'h81;
        step();
        n_checks++; if (bus.int_out !== 1'b1) $display("FAIL rmid_int_after got=%b exp=1", bus.int_out); else n_pass++;
        run_inta(0, 0, 0, c1, c2, i1, t1, dv, ev, im, ea, ia);
        m_isr[0] = 1'b1;
        n_checks++; if (c1 !== 8'h01) $display("FAIL rmid_prio_clr got=%h exp=01", c1); else n_pass++;
        n_checks++; if (dv !== 8'h88) $display("FAIL rmid_dout_after got=%h exp=88", dv); else n_pass++;
        bus.interrupt_req_reg = 8'h00;
        pulse_eoi(0, 0, 3'd0);
        m_eoi(0, 0, 0);
    endtask

    task automatic test_random();
        bit [7:0] req;
        bit [7:0] mask;
        bit [4:0] base;
        bit       rot;
        bit       ea_eoi;
        bit       ea_spec;
        bit [2:0] ea_lvl;
        int       lvl;
        logic [7:0] exp_clr;
        logic [7:0] exp_dout;
        for (int it = 0; it < 40; it++) begin
            req     = 8'($urandom);
            mask    = 8'($urandom & $urandom);
            base    = 5'($urandom);
            rot     = 1'($urandom);
            ea_eoi  = ($urandom_range(0, 3) == 0);
            ea_spec = 1'($urandom);
            ea_lvl  = 3'($urandom);
            bus.interrupt_req_reg = req;
            bus.interrupt_mask    = mask;
            bus.vector_base       = base;
            bus.auto_eoi          = 1'($urandom);
            bus.eoi_rotate        = rot;
            step();
            step();
            lvl = m_qual(req, mask);
            n_checks++; if (bus.int_out !== (lvl >= 0)) $display("FAIL rnd_int it=%0d got=%b exp=%b", it, bus.int_out, lvl >= 0); else n_pass++;
            run_inta(ea_eoi, ea_spec, ea_lvl, c1, c2, i1, t1, dv, ev, im, ea, ia);
            if (ea_eoi) m_eoi(ea_spec, rot, int'(ea_lvl));
            if (lvl >= 0) m_isr[lvl] = 1'b1;
            exp_clr  = (lvl >= 0) ? (8'(1) << lvl) : 8'h00;
            exp_dout = {base, (lvl >= 0) ? 3'(lvl) : 3'd7};
            n_checks++; if (c1 !== exp_clr) $display("FAIL rnd_clr it=%0d got=%h exp=%h", it, c1, exp_clr); else n_pass++;
            n_checks++; if (i1 !== m_isr) $display("FAIL rnd_isr_ack it=%0d got=%h exp=%h", it, i1, m_isr); else n_pass++;
            n_checks++; if (dv !== exp_dout) $display("FAIL rnd_dout it=%0d got=%h exp=%h", it, dv, exp_dout); else n_pass++;
            n_checks++; if ({ev, ea} !== 2'b10) $display("FAIL rnd_en it=%0d got=%b exp=10", it, {ev, ea}); else n_pass++;
            if (bus.auto_eoi && lvl >= 0) begin
                m_isr[lvl] = 1'b0;
                if (rot) m_low = lvl;
            end
            n_checks++; if (ia !== m_isr) $display("FAIL rnd_isr_end it=%0d got=%h exp=%h", it, ia, m_isr); else n_pass++;
            if ($urandom_range(0, 1) == 1) begin
                ea_spec = 1'($urandom);
                ea_lvl  = 3'($urandom);
                rot     = 1'($urandom);
                pulse_eoi(ea_spec, rot, ea_lvl);
                m_eoi(ea_spec, rot, int'(ea_lvl));
                n_checks++; if (bus.in_service_reg !== m_isr) $display("FAIL rnd_eoi it=%0d got=%h exp=%h", it, bus.in_service_reg, m_isr); else n_pass++;
            end
        end
    endtask

    initial begin
        reset_n               = 1'b0;
        bus.interrupt_req_reg = 8'h00;
        bus.interrupt_mask    = 8'h00;
        bus.inta_n            = 1'b1;
        bus.vector_base       = 5'h00;
        bus.auto_eoi          = 1'b0;
        bus.eoi_valid         = 1'b0;
        bus.eoi_specific      = 1'b0;
        bus.eoi_rotate        = 1'b0;
        bus.eoi_level         = 3'd0;
        m_isr = '0;
        m_low = 7;
        test_reset();
        test_single();
        test_nesting();
        test_nonspecific_eoi();
        test_rotating();
        test_spurious();
        test_aeoi();
        test_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
